lif_tdm_scheduler: RTL

Time-multiplexed scheduler that shares one leaky-integrate-fire update datapath across N_NEURONS virtual neurons. A prescaler generates the neuron time step ("tick"). On each tick the scheduler snapshots the stimulus inputs and sequences every neuron once through leak, integrate, threshold, reset and refractory handling. Potentials and refractory state are held in per-neuron registers. It sits beside the neuron top level, between the input switches and the spike/monitor outputs.

---
 rtl/lif_tdm_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/lif_tdm_scheduler.sv
// lif_tdm_scheduler: one shared leaky-integrate-fire datapath, time-multiplexed
// over N_NEURONS virtual neurons. A prescaler produces the neuron time step;
// each tick snapshots the stimulus and walks every neuron once through leak,
// integrate, threshold, reset and refractory handling.
// Optional feature macro: LIF_SPIKE_COUNT_EN (per-neuron 8-bit saturating
// spike counters readable on spike_cnt; tied to 0 when undefined).
module lif_tdm_scheduler #(
    parameter int                 N_NEURONS     = 4,
    parameter int                 V_WIDTH       = 8,
    parameter logic [V_WIDTH-1:0] THRESHOLD     = 8'd200,
    parameter int                 LEAK_SHIFT    = 3,
    parameter int                 REFRACT_TICKS = 2,
    parameter logic [23:0]        TICK_DIV      = 24'd10_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_NEURONS-1:0] stim,
    input  logic [7:0]           weight,
    input  logic [2:0]           v_sel,
    output logic [N_NEURONS-1:0] spike_out,
    output logic [V_WIDTH-1:0]   v_mon,
    output logic [7:0]           spike_cnt,
    output logic                 busy,
    output logic                 tick,
    output logic                 overrun
);

    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

    typedef enum logic [1:0] {IDLE, SAMPLE, UPDATE, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [23:0]            pre_q, pre_d;
    logic [IDX_W-1:0]       idx_q;
    logic [N_NEURONS-1:0]   stim_snap_q;
    logic [7:0]             w_snap_q;
    logic [N_NEURONS-1:0]   spike_next_q;
    logic [N_NEURONS-1:0]   spike_out_q;
    logic                   overrun_q;
    logic [V_WIDTH-1:0]     v_q       [N_NEURONS];
    logic [2:0]             refract_q [N_NEURONS];

    logic                   last_idx;
    logic [V_WIDTH-1:0]     v_cur, v_leak, v_vl, v_vs;
    logic [V_WIDTH:0]       v_sum;
    logic [2:0]             refr_cur;
    logic                   fire;

    // Prescaler next count and tick pulse; en=0 freezes the count.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        pre_d = pre_q;
        tick  = 1'b0;
        if (en) begin
            if (pre_q == TICK_DIV - 24'd1) begin
                pre_d = '0;
                tick  = 1'b1;
            end else begin
                pre_d = pre_q + 24'd1;
            end
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    assign last_idx = (idx_q == IDX_W'(N_NEURONS - 1));

    // FSM next-state: IDLE -> SAMPLE -> UPDATE (N cycles) -> COMMIT -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick) state_d = SAMPLE;
            SAMPLE:  state_d = UPDATE;
            UPDATE:  if (last_idx) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy for the whole pass.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Shared LIF datapath for the neuron selected by idx_q.
    always_comb begin
        v_cur    = v_q[idx_q];
        refr_cur = refract_q[idx_q];
        v_leak   = v_cur >> LEAK_SHIFT;
        v_vl     = v_cur - v_leak;
        v_sum    = {1'b0, v_vl} + (stim_snap_q[idx_q] ? (V_WIDTH+1)'(w_snap_q) : '0);
        v_vs     = v_sum[V_WIDTH] ? '1 : v_sum[V_WIDTH-1:0];
        fire     = (v_vs >= THRESHOLD);
    end

    // Pass sequencing: snapshot, per-neuron update, commit of the spike vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            stim_snap_q  <= '0;
            w_snap_q     <= '0;
            spike_next_q <= '0;
            spike_out_q  <= '0;
            // NOTE: neuron state arrays are plain flops with async reset, so a
            // reset mid-pass leaves every neuron clean; they must not map to RAM.
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]       <= '0;
                refract_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                SAMPLE: begin
                    stim_snap_q  <= stim;
                    w_snap_q     <= weight;
                    idx_q        <= '0;
                    spike_next_q <= '0;
                end
                UPDATE: begin
                    if (refr_cur != 3'd0) begin
                        refract_q[idx_q] <= refr_cur - 3'd1;
                        v_q[idx_q]       <= '0;
                    end else if (fire) begin
                        spike_next_q[idx_q] <= 1'b1;
                        v_q[idx_q]          <= '0;
                        refract_q[idx_q]    <= 3'(REFRACT_TICKS);
                    end else begin
                        v_q[idx_q] <= v_vs;
                    end
                    if (!last_idx) idx_q <= idx_q + 1'b1;
                end
                COMMIT:  spike_out_q <= spike_next_q;
                default: ;
            endcase
        end
    end

    // Sticky overrun: a tick that lands while a pass is running is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         overrun_q <= 1'b0;
        else if (tick && state_q != IDLE) overrun_q <= 1'b1;
    end

    assign spike_out = spike_out_q;
    assign overrun   = overrun_q;

    // Monitor read of the selected neuron potential; out-of-range reads 0.
    always_comb begin
        v_mon = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (v_sel == 3'(i)) v_mon = v_q[i];
        end
    end

`ifdef LIF_SPIKE_COUNT_EN
    logic [7:0] cnt_q [N_NEURONS];

    // Per-neuron saturating spike counters, bumped when a pass commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) cnt_q[i] <= '0;
        end else if (state_q == COMMIT) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (spike_next_q[i] && cnt_q[i] != 8'hFF) cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

    // Monitor read of the selected neuron spike count.
    always_comb begin
        spike_cnt = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (v_sel == 3'(i)) spike_cnt = cnt_q[i];
        end
    end
`else
    assign spike_cnt = '0;
`endif

endmodule
